// File: rtl/fft_output_reorder.sv
// fft_output_reorder
//   Captures one FFT frame from the 4-lane output bus of fft_top, which emits it
//   in digit-reversed order. Reorders the frame into natural frequency order and
//   streams it out one complex sample per cycle over a valid/ready handshake.
//
// Build option:
//   FFT_DIGIT_REVERSE_EN - defined: frame is reordered to natural frequency order.
//                          undefined: frame is replayed in core order, and no
//                          digit-reverse logic is built.
//
// Ports:
//   clock, reset                 clock and asynchronous active-high reset
//   in_en                        beat qualifier (fft_top.output_en)
//   in_real_0..3, in_imag_0..3   lane data; lane k of beat b is core sample 4b+k
//   out_valid / out_ready        output handshake
//   out_real, out_imag           current sample
//   out_index                    bin index of the current sample (read pointer)
//   out_last                     marks bin N-1
//   busy                         high while filling or draining
//   overflow                     sticky: a beat arrived while draining and was dropped
module fft_output_reorder #(
  parameter int WIDTH          = 16,
  parameter int Num_of_samples = 256
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              in_en,
  input  logic [WIDTH-1:0]                  in_real_0,
  input  logic [WIDTH-1:0]                  in_real_1,
  input  logic [WIDTH-1:0]                  in_real_2,
  input  logic [WIDTH-1:0]                  in_real_3,
  input  logic [WIDTH-1:0]                  in_imag_0,
  input  logic [WIDTH-1:0]                  in_imag_1,
  input  logic [WIDTH-1:0]                  in_imag_2,
  input  logic [WIDTH-1:0]                  in_imag_3,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [WIDTH-1:0]                  out_real,
  output logic [WIDTH-1:0]                  out_imag,
  output logic [$clog2(Num_of_samples)-1:0] out_index,
  output logic                              out_last,
  output logic                              busy,
  output logic                              overflow
);

  localparam int N     = Num_of_samples;
  localparam int BEATS = N / 4;
  localparam int AW    = $clog2(N);
  localparam int BW    = $clog2(BEATS);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

  state_t state, next_state;

  logic [WIDTH-1:0] mem_real [N];
  logic [WIDTH-1:0] mem_imag [N];

  logic [BW-1:0] wr_beat;
  logic [AW-1:0] rd_ptr;
  logic          wr_accept;
  logic          xfer;

  logic [WIDTH-1:0] lane_real [4];
  logic [WIDTH-1:0] lane_imag [4];
  logic [AW-1:0]    wr_addr   [4];

`ifdef FFT_DIGIT_REVERSE_EN
  localparam int DIGITS = AW / 2;

  // Reverse the order of the 2-bit base-4 digits.
  function automatic logic [AW-1:0] digit_rev(input logic [AW-1:0] n);
    logic [AW-1:0] r;
    r = '0;
    for (int unsigned d = 0; d < DIGITS; d++)
      r[2*d +: 2] = n[AW-2-2*d +: 2];
    return r;
  endfunction
`endif

  always_comb begin
    lane_real[0] = in_real_0;
    lane_real[1] = in_real_1;
    lane_real[2] = in_real_2;
    lane_real[3] = in_real_3;
    lane_imag[0] = in_imag_0;
    lane_imag[1] = in_imag_1;
    lane_imag[2] = in_imag_2;
    lane_imag[3] = in_imag_3;
    for (int unsigned k = 0; k < 4; k++) begin
`ifdef FFT_DIGIT_REVERSE_EN
      wr_addr[k] = digit_rev({wr_beat, 2'(k)});
`else
      wr_addr[k] = {wr_beat, 2'(k)};
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    wr_accept  = 1'b0;
    xfer       = 1'b0;
    case (state)
      IDLE: begin
        if (in_en) begin
          wr_accept  = 1'b1;
          next_state = FILL;
        end
      end
      FILL: begin
        if (in_en) begin
          wr_accept = 1'b1;
          if (wr_beat == BW'(BEATS - 1)) next_state = DRAIN;
        end
      end
      DRAIN: begin
        xfer = out_ready;
        if (out_ready && rd_ptr == AW'(N - 1)) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Both counters wrap naturally: wr_beat returns to 0 after the last beat and
  // rd_ptr returns to 0 after the last transfer, ready for the next frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_beat  <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_accept)            wr_beat  <= wr_beat + 1'b1;
      if (xfer)                 rd_ptr   <= rd_ptr + 1'b1;
      if (state == DRAIN && in_en) overflow <= 1'b1;
    end
  end

  // Frame storage is deliberately not reset.
  always_ff @(posedge clock) begin
    if (wr_accept) begin
      for (int unsigned k = 0; k < 4; k++) begin
        mem_real[wr_addr[k]] <= lane_real[k];
        mem_imag[wr_addr[k]] <= lane_imag[k];
      end
    end
  end

  assign out_valid = (state == DRAIN);
  assign out_index = rd_ptr;
  assign out_last  = (state == DRAIN) && (rd_ptr == AW'(N - 1));
  assign busy      = (state != IDLE);
  assign out_real  = mem_real[rd_ptr];
  assign out_imag  = mem_imag[rd_ptr];

endmodule

// File: tb/tb_fft_output_reorder.sv
// Testbench for fft_output_reorder (N=16, WIDTH=16). Frames are applied as
// directed or random data; a frame model in core order predicts each output
// bin by base-4 digit reversal of the bin index (when FFT_DIGIT_REVERSE_EN is
// defined) or by identity.
module tb_fft_output_reorder;

  localparam int N     = 16;
  localparam int W     = 16;
  localparam int BEATS = N / 4;
  localparam int DIGITS = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_en;
  logic [W-1:0]  lr [4];
  logic [W-1:0]  li [4];
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_real;
  logic [W-1:0]  out_imag;
  logic [3:0]    out_index;
  logic          out_last;
  logic          busy;
  logic          overflow;

  int vectors    = 0;
  int miscompares = 0;

  logic [W-1:0] core_r [N];
  logic [W-1:0] core_i [N];

  fft_output_reorder #(.WIDTH(W), .Num_of_samples(N)) dut (
    .clock(clock), .reset(reset), .in_en(in_en),
    .in_real_0(lr[0]), .in_real_1(lr[1]), .in_real_2(lr[2]), .in_real_3(lr[3]),
    .in_imag_0(li[0]), .in_imag_1(li[1]), .in_imag_2(li[2]), .in_imag_3(li[3]),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_real(out_real), .out_imag(out_imag), .out_index(out_index),
    .out_last(out_last), .busy(busy), .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Core-order position of natural bin i.
  function automatic int src_of(input int i);
    int s, t;
`ifdef FFT_DIGIT_REVERSE_EN
    s = 0;
    t = i;
    for (int d = 0; d < DIGITS; d++) begin
      s = s * 4 + t % 4;
      t = t / 4;
    end
`else
    s = i;
    t = 0;
`endif
    return s;
  endfunction

  // gaps < 0 selects a random 0..3 idle cycles between beats.
  task automatic send_frame(input int gaps, input bit directed);
    int g;
    for (int b = 0; b < BEATS; b++) begin
      check("pre_valid", 32'(out_valid), 32'd0);
      in_en = 1'b1;
      for (int k = 0; k < 4; k++) begin
        if (directed) begin
          lr[k] = W'(4 * b + k);
          li[k] = W'(100 + 4 * b + k);
        end else begin
          lr[k] = W'($urandom);
          li[k] = W'($urandom);
        end
        core_r[4 * b + k] = lr[k];
        core_i[4 * b + k] = li[k];
      end
      out_ready = 1'($urandom);
      step();
      in_en = 1'b0;
      if (b < BEATS - 1) begin
        check("fill_busy", 32'(busy), 32'd1);
        g = (gaps < 0) ? int'($urandom_range(0, 3)) : gaps;
        repeat (g) begin
          check("gap_valid", 32'(out_valid), 32'd0);
          step();
        end
      end
    end
    check("handoff_valid", 32'(out_valid), 32'd1);
  endtask

  // ready_mode: 0 always ready, 1 pattern 1,0,0,..., 2 random.
  task automatic drain(input int ready_mode, input int ovf_at, input int stop_after);
    int  i, cyc, src;
    bit  rdy, inj;
    i = 0;
    cyc = 0;
    while (i < stop_after && cyc < 400) begin
      src = src_of(i);
      check("valid", 32'(out_valid), 32'd1);
      check("index", 32'(out_index), 32'(i));
      check("real", 32'(out_real), 32'(core_r[src]));
      check("imag", 32'(out_imag), 32'(core_i[src]));
      check("last", 32'(out_last), 32'(i == N - 1));
      case (ready_mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom);
      endcase
      out_ready = rdy;
      inj = (i == ovf_at) && rdy;
      if (inj) begin
        check("ovf_pre", 32'(overflow), 32'd0);
        in_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
          lr[k] = 16'hDEAD;
          li[k] = 16'hBEEF;
        end
      end
      step();
      in_en = 1'b0;
      if (inj) check("ovf_set", 32'(overflow), 32'd1);
      if (rdy) i++;
      cyc++;
    end
    if (i < stop_after) check("drain_timeout", 32'(i), 32'(stop_after));
    if (stop_after == N) begin
      check("end_valid", 32'(out_valid), 32'd0);
      check("end_busy", 32'(busy), 32'd0);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    in_en = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      lr[k] = '0;
      li[k] = '0;
    end
    repeat (2) step();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_index", 32'(out_index), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    reset = 1'b0;
    step();

    // Directed reorder, back-to-back beats, always ready.
    send_frame(0, 1'b1);
    drain(0, -1, N);

    // Backpressure 1,0,0 with random data.
    send_frame(0, 1'b0);
    drain(1, -1, N);

    // Gapped input, 3 idle cycles between beats.
    send_frame(3, 1'b1);
    drain(0, -1, N);

    // Random frames, random gaps, random ready; next frame starts right after
    // the last transfer.
    for (int f = 0; f < 6; f++) begin
      send_frame(-1, 1'b0);
      drain(2, -1, N);
    end
    check("ovf_still0", 32'(overflow), 32'd0);

    // Overflow: one beat during DRAIN, then an immediate new frame.
    send_frame(0, 1'b0);
    drain(0, 7, N);
    send_frame(0, 1'b0);
    check("ovf_sticky", 32'(overflow), 32'd1);
    drain(2, -1, N);
    check("ovf_sticky2", 32'(overflow), 32'd1);

    // Reset mid-DRAIN after 5 transfers.
    send_frame(1, 1'b0);
    drain(0, -1, 5);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    check("mid_rst_index", 32'(out_index), 32'd0);
    reset = 1'b0;
    step();
    send_frame(0, 1'b0);
    drain(2, -1, N);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
